// File: rtl/shift_feeder.sv
// shift_feeder: parallel-to-serial feeder for a downstream right-shifting serial-in register.
// Takes one word per Load/Ready handshake, shifts it out over WIDTH cycles, pulses Done, then idles GAP cycles.
module shift_feeder #(
    parameter int WIDTH     = 4,
    parameter int GAP       = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic             Ck,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load,
    output logic             Ready,
    output logic             Shift,
    output logic             SI,
    output logic             Done,
    output logic             Busy,
    output logic [7:0]       WordCnt
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]    LAST_GAP = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        GAPW
    } state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic [WIDTH-1:0] data_buf;

    // Bit n of the serial stream, honouring the configured bit order.
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] n);
        if (LSB_FIRST != 0)
            return w[n];
        return w[LAST_BIT - n];
    endfunction

    assign Ready = (state == IDLE);

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Ck) begin
        if (Reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            data_buf <= '0;
            Shift    <= 1'b0;
            SI       <= 1'b0;
            Done     <= 1'b0;
            Busy     <= 1'b0;
            WordCnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        // The first bit is registered here so it appears one cycle after acceptance.
                        data_buf <= Din;
                        bit_cnt  <= '0;
                        Shift    <= 1'b1;
                        SI       <= pick(Din, '0);
                        Busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        Shift   <= 1'b0;
                        SI      <= 1'b0;
                        Done    <= 1'b1;
                        Busy    <= 1'b0;
                        WordCnt <= WordCnt + 8'd1;
                        state   <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                        SI      <= pick(data_buf, bit_cnt + CW'(1));
                    end
                end
                DONE: begin
                    Done    <= 1'b0;
                    gap_cnt <= '0;
                    if (GAP > 0) begin
                        Busy  <= 1'b1;
                        state <= GAPW;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAPW: begin
                    if (gap_cnt == LAST_GAP) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_feeder.sv
// Bench for shift_feeder: three instances (LSB/GAP1, MSB/GAP1, LSB/GAP0) feeding modelled downstream registers.
// Expected downstream words are queued at acceptance and compared when Done is seen.
module tb_shift_feeder;

    localparam bit [2:0]   LSBS = 3'b101;
    localparam bit [11:0]  GAPS = {4'd0, 4'd1, 4'd1};

    logic       ck = 1'b0;
    logic       rst;
    logic       load  [3];
    logic [3:0] din   [3];
    logic       ready [3];
    logic       shift [3];
    logic       si    [3];
    logic       done  [3];
    logic       busy  [3];
    logic [7:0] wcnt  [3];
    logic [3:0] q_ds  [3];

    logic [3:0] exp_q [$];
    int         cnt_exp [3];
    int         checks   = 0;
    int         failures = 0;

    always #5 ck = ~ck;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        shift_feeder #(
            .WIDTH    (4),
            .GAP      (int'(GAPS[g*4 +: 4])),
            .LSB_FIRST(int'(LSBS[g]))
        ) u_dut (
            .Ck     (ck),
            .Reset  (rst),
            .Din    (din[g]),
            .Load   (load[g]),
            .Ready  (ready[g]),
            .Shift  (shift[g]),
            .SI     (si[g]),
            .Done   (done[g]),
            .Busy   (busy[g]),
            .WordCnt(wcnt[g])
        );
    end

    // Downstream 4-bit right-shifting serial-in register model.
    always @(posedge ck)
        for (int i = 0; i < 3; i++)
            if (shift[i]) q_ds[i] <= {si[i], q_ds[i][3:1]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

    // Send one word on instance i starting from an IDLE-cycle negedge; returns at the next IDLE negedge.
    task automatic run_word(input int i, input logic [3:0] d, input bit change_din);
        int gap;
        gap = int'(GAPS[i*4 +: 4]);
        check($sformatf("u%0d_ready_pre", i), ready[i], 1);
        din[i]  = d;
        load[i] = 1'b1;
        exp_q.push_back(LSBS[i] ? d : rev4(d));
        for (int k = 0; k < 4; k++) begin
            @(negedge ck);
            if (k == 0) begin
                load[i] = 1'b0;
                if (change_din) din[i] = ~d;
            end
            check($sformatf("u%0d_shift_b%0d", i, k), shift[i], 1);
            check($sformatf("u%0d_si_b%0d", i, k), si[i], LSBS[i] ? d[k] : d[3-k]);
            check($sformatf("u%0d_busy_b%0d", i, k), busy[i], 1);
        end
        @(negedge ck);
        cnt_exp[i] = (cnt_exp[i] + 1) % 256;
        check($sformatf("u%0d_done", i), done[i], 1);
        check($sformatf("u%0d_shift_done", i), shift[i], 0);
        check($sformatf("u%0d_si_done", i), si[i], 0);
        check($sformatf("u%0d_wordcnt", i), wcnt[i], cnt_exp[i]);
        check($sformatf("u%0d_downstream_q", i), q_ds[i], exp_q.pop_front());
        for (int g = 0; g < gap; g++) begin
            @(negedge ck);
            check($sformatf("u%0d_gap_done", i), done[i], 0);
            check($sformatf("u%0d_gap_busy", i), busy[i], 1);
            check($sformatf("u%0d_gap_ready", i), ready[i], 0);
            check($sformatf("u%0d_gap_shift", i), shift[i], 0);
        end
        @(negedge ck);
        check($sformatf("u%0d_idle_ready", i), ready[i], 1);
        check($sformatf("u%0d_idle_done", i), done[i], 0);
        check($sformatf("u%0d_idle_busy", i), busy[i], 0);
    endtask

    initial begin
        int shift_cnt;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load[i]    = 1'b0;
            din[i]     = 4'd0;
            cnt_exp[i] = 0;
        end

        // Reset state.
        @(negedge ck);
        @(negedge ck);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_rst_ready", i), ready[i], 1);
            check($sformatf("u%0d_rst_shift", i), shift[i], 0);
            check($sformatf("u%0d_rst_si", i), si[i], 0);
            check($sformatf("u%0d_rst_done", i), done[i], 0);
            check($sformatf("u%0d_rst_busy", i), busy[i], 0);
            check($sformatf("u%0d_rst_wordcnt", i), wcnt[i], 0);
        end

        // Reset during the 3rd shift cycle abandons the word.
        din[0]  = 4'b1010;
        load[0] = 1'b1;
        @(negedge ck);
        load[0] = 1'b0;
        check("abort_shift_c1", shift[0], 1);
        @(negedge ck);
        @(negedge ck);
        check("abort_shift_c3", shift[0], 1);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        check("abort_shift", shift[0], 0);
        check("abort_si", si[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_ready", ready[0], 1);
        check("abort_wordcnt", wcnt[0], 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge ck);
            check("abort_no_done", done[0], 0);
        end

        // Load and Reset on the same edge: nothing accepted.
        din[0]  = 4'b1111;
        load[0] = 1'b1;
        rst     = 1'b1;
        @(negedge ck);
        load[0] = 1'b0;
        rst     = 1'b0;
        check("ldrst_ready", ready[0], 1);
        @(negedge ck);
        check("ldrst_shift", shift[0], 0);
        check("ldrst_busy", busy[0], 0);
        check("ldrst_wordcnt", wcnt[0], 0);

        // Directed words: LSB-first, MSB-first, Din changed mid-word.
        run_word(0, 4'b1011, 1'b0);
        run_word(1, 4'b1000, 1'b0);
        run_word(0, 4'b0011, 1'b1);

        // Load held high with GAP=0: second word only taken in the IDLE cycle after Done.
        din[2]  = 4'b0110;
        load[2] = 1'b1;
        exp_q.push_back(4'b0110);
        exp_q.push_back(4'b1111);
        shift_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge ck);
            if (c == 1) din[2] = 4'b1111;
            if (shift[2]) shift_cnt++;
            check($sformatf("b2b_ready_c%0d", c), ready[2], (c == 0 || c == 6));
            check($sformatf("b2b_done_c%0d", c), done[2], (c == 5 || c == 11));
            if (c == 5 || c == 11)
                check($sformatf("b2b_q_c%0d", c), q_ds[2], exp_q.pop_front());
            if (c == 11) load[2] = 1'b0;
        end
        cnt_exp[2] += 2;
        check("b2b_shift_count", shift_cnt, 8);
        check("b2b_wordcnt", wcnt[2], cnt_exp[2]);
        @(negedge ck);
        check("b2b_idle_ready", ready[2], 1);

        // 256 words from a fresh reset: count wraps 255 -> 0.
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cnt_exp[i] = 0;
        for (int w = 1; w <= 256; w++)
            run_word(2, 4'($urandom_range(0, 15)), 1'b0);
        check("wrap_wordcnt", wcnt[2], 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
